// File: rtl/rv_int_ctrl_if.sv
// CSR struct types and the timer-bus / trap-handshake interface shared by
// the machine interrupt controller and the core.
package rv_int_ctrl_pkg;
    typedef struct packed {
        logic enable_external;
        logic enable_timer;
        logic enable_soft;
    } int_ctrl_csr_t;

    typedef struct packed {
        logic pending_external;
        logic pending_timer;
        logic pending_soft;
    } int_ctrl_state_csr_t;
endpackage

interface rv_int_ctrl_if;
    logic        i_tmr_we;
    logic [1:0]  i_tmr_sel;
    logic [31:0] i_tmr_wdata;
    logic [31:0] o_tmr_rdata;
    logic        o_trap_req;
    logic        i_trap_ack;
    logic [31:0] o_trap_cause;
    logic        i_mret;
    logic        o_in_trap;

    // master is the core side, slave is the interrupt controller
    modport master (
        output i_tmr_we, i_tmr_sel, i_tmr_wdata, i_trap_ack, i_mret,
        input  o_tmr_rdata, o_trap_req, o_trap_cause, o_in_trap
    );

    modport slave (
        input  i_tmr_we, i_tmr_sel, i_tmr_wdata, i_trap_ack, i_mret,
        output o_tmr_rdata, o_trap_req, o_trap_cause, o_in_trap
    );
endinterface

// File: rtl/rv_int_ctrl.sv
// Machine-mode interrupt controller: 64-bit mtime/mtimecmp timer, external IRQ
// synchronizer, fixed-priority arbitration and a trap request/ack/mret FSM.
module rv_int_ctrl
    import rv_int_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_irq_ext,
    input  logic                i_irq_soft,
    input  int_ctrl_csr_t       i_int_ctr,
    input  logic                i_mie,
    output int_ctrl_state_csr_t o_int_ctr_state,
    rv_int_ctrl_if.slave        bus
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("rv_int_ctrl: SYNC_STAGES must be in 2..4");
    end

    localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_SOFT  = 32'h8000_0003;
    localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACTIVE
    } state_t;

    // Fixed priority: external > soft > timer; cand is {ext, soft, timer}
    function automatic logic [31:0] win_cause(input logic [2:0] cand);
        if (cand[2])      return CAUSE_EXT;
        else if (cand[1]) return CAUSE_SOFT;
        else              return CAUSE_TIMER;
    endfunction

    logic [63:0]            mtime;
    logic [63:0]            mtimecmp;
    logic [SYNC_STAGES-1:0] irq_ext_sync;
    logic                   pend_timer;
    logic                   pend_soft;
    logic [2:0]             cand;
    state_t                 state;
    logic                   trap_req;
    logic [31:0]            trap_cause;
    logic                   in_trap;

    // A write to either mtime half replaces this cycle's increment entirely
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            mtime <= 64'd0;
        end else if (bus.i_tmr_we && bus.i_tmr_sel == 2'd0) begin
            mtime[31:0] <= bus.i_tmr_wdata;
        end else if (bus.i_tmr_we && bus.i_tmr_sel == 2'd1) begin
            mtime[63:32] <= bus.i_tmr_wdata;
        end else begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (bus.i_tmr_we && bus.i_tmr_sel == 2'd2) begin
            mtimecmp[31:0] <= bus.i_tmr_wdata;
        end else if (bus.i_tmr_we && bus.i_tmr_sel == 2'd3) begin
            mtimecmp[63:32] <= bus.i_tmr_wdata;
        end
    end

    always_comb begin
        bus.o_tmr_rdata = 32'd0;
        case (bus.i_tmr_sel)
            2'd0:    bus.o_tmr_rdata = mtime[31:0];
            2'd1:    bus.o_tmr_rdata = mtime[63:32];
            2'd2:    bus.o_tmr_rdata = mtimecmp[31:0];
            default: bus.o_tmr_rdata = mtimecmp[63:32];
        endcase
    end

    // Pending sources: external through the synchronizer, others one flop
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            irq_ext_sync <= '0;
            pend_timer   <= 1'b0;
            pend_soft    <= 1'b0;
        end else begin
            irq_ext_sync <= {irq_ext_sync[SYNC_STAGES-2:0], i_irq_ext};
            pend_timer   <= (mtime >= mtimecmp);
            pend_soft    <= i_irq_soft;
        end
    end

    assign o_int_ctr_state.pending_external = irq_ext_sync[SYNC_STAGES-1];
    assign o_int_ctr_state.pending_timer    = pend_timer;
    assign o_int_ctr_state.pending_soft     = pend_soft;

    assign cand = {irq_ext_sync[SYNC_STAGES-1] & i_int_ctr.enable_external,
                   pend_soft                   & i_int_ctr.enable_soft,
                   pend_timer                  & i_int_ctr.enable_timer};

    // Once raised, the request is held until acknowledged regardless of sources
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            trap_req   <= 1'b0;
            trap_cause <= 32'd0;
            in_trap    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_mie && (cand != 3'b000)) begin
                        state      <= REQ;
                        trap_req   <= 1'b1;
                        trap_cause <= win_cause(cand);
                    end
                end
                REQ: begin
                    if (bus.i_trap_ack) begin
                        state    <= ACTIVE;
                        trap_req <= 1'b0;
                        in_trap  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (bus.i_mret) begin
                        state   <= IDLE;
                        in_trap <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    trap_req <= 1'b0;
                    in_trap  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_trap_req   = trap_req;
    assign bus.o_trap_cause = trap_cause;
    assign bus.o_in_trap    = in_trap;

endmodule

// File: tb/tb_rv_int_ctrl.sv
// Randomized plus directed bench for rv_int_ctrl against a cycle-level
// behavioural model of the timer, pending sources and trap handshake.
module tb_rv_int_ctrl;
    import rv_int_ctrl_pkg::*;

    localparam int SS = 2;

    logic                clk;
    logic                rst_n;
    logic                irq_ext;
    logic                irq_soft;
    logic                mie;
    int_ctrl_csr_t       en;
    int_ctrl_state_csr_t st;

    rv_int_ctrl_if bus ();

    rv_int_ctrl #(.SYNC_STAGES(SS)) dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_irq_ext       (irq_ext),
        .i_irq_soft      (irq_soft),
        .i_int_ctr       (en),
        .i_mie           (mie),
        .o_int_ctr_state (st),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    bit [63:0] m_time;
    bit [63:0] m_cmp;
    bit        m_pt;
    bit        m_ps;
    bit [3:0]  m_sync;
    bit        m_req;
    bit        m_act;
    bit [31:0] m_cause;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [31:0] model_rd(input logic [1:0] sel);
        case (sel)
            2'd0:    return m_time[31:0];
            2'd1:    return m_time[63:32];
            2'd2:    return m_cmp[31:0];
            default: return m_cmp[63:32];
        endcase
    endfunction

    // Next-cycle model state from the inputs presented before the edge
    task automatic model_step();
        bit [2:0] cand;
        if (!rst_n) begin
            m_time = 64'd0;
            m_cmp = '1;
            m_pt = 0; m_ps = 0; m_sync = '0;
            m_req = 0; m_act = 0; m_cause = 32'd0;
        end else begin
            cand = {m_sync[SS-1] & en.enable_external, m_ps & en.enable_soft, m_pt & en.enable_timer};
            if (m_act) begin
                if (bus.i_mret) m_act = 0;
            end else if (m_req) begin
                if (bus.i_trap_ack) begin m_req = 0; m_act = 1; end
            end else if (mie && cand != 0) begin
                m_req = 1;
                m_cause = cand[2] ? 32'h8000_000B : cand[1] ? 32'h8000_0003 : 32'h8000_0007;
            end
            m_pt = (m_time >= m_cmp);
            m_ps = irq_soft;
            m_sync = {m_sync[2:0], irq_ext};
            if (bus.i_tmr_we && bus.i_tmr_sel == 2'd0)      m_time = {m_time[63:32], bus.i_tmr_wdata};
            else if (bus.i_tmr_we && bus.i_tmr_sel == 2'd1) m_time = {bus.i_tmr_wdata, m_time[31:0]};
            else                                            m_time = m_time + 64'd1;
            if (bus.i_tmr_we && bus.i_tmr_sel == 2'd2) m_cmp[31:0]  = bus.i_tmr_wdata;
            if (bus.i_tmr_we && bus.i_tmr_sel == 2'd3) m_cmp[63:32] = bus.i_tmr_wdata;
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            model_step();
            @(posedge clk);
            #1;
            chk("trap_req", 64'(bus.o_trap_req), 64'(m_req));
            chk("in_trap", 64'(bus.o_in_trap), 64'(m_act));
            chk("trap_cause", 64'(bus.o_trap_cause), 64'(m_cause));
            chk("pending", 64'(st), 64'({m_sync[SS-1], m_pt, m_ps}));
            chk("tmr_rdata", 64'(bus.o_tmr_rdata), 64'(model_rd(bus.i_tmr_sel)));
        end
    endtask

    task automatic tmr_write(input logic [1:0] sel, input logic [31:0] data);
        bus.i_tmr_we = 1'b1; bus.i_tmr_sel = sel; bus.i_tmr_wdata = data;
        tick();
        bus.i_tmr_we = 1'b0; bus.i_tmr_sel = 2'd0;
    endtask

    task automatic wait_req(input int bound);
        for (int i = 0; i < bound && !bus.o_trap_req; i++) tick();
        chk("wait_req", 64'(bus.o_trap_req), 64'd1);
    endtask

    task automatic ack_cycle();
        bus.i_trap_ack = 1'b1; tick(); bus.i_trap_ack = 1'b0;
    endtask

    task automatic mret_cycle();
        bus.i_mret = 1'b1; tick(); bus.i_mret = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq_ext = 1'b0; irq_soft = 1'b0; mie = 1'b0; en = '0;
        bus.i_tmr_we = 1'b0; bus.i_tmr_sel = 2'd3; bus.i_tmr_wdata = 32'd0;
        bus.i_trap_ack = 1'b0; bus.i_mret = 1'b0;
        tick(2);
        chk("rst_cmp_hi", 64'(bus.o_tmr_rdata), 64'hFFFF_FFFF);
        bus.i_tmr_sel = 2'd0; #1;
        chk("rst_mtime_lo", 64'(bus.o_tmr_rdata), 64'd0);
        chk("rst_trap_req", 64'(bus.o_trap_req), 64'd0);
        rst_n = 1'b1;

        // Timer interrupt at mtimecmp = 0x10
        mie = 1'b1; en = '{enable_external: 1'b0, enable_timer: 1'b1, enable_soft: 1'b0};
        tmr_write(2'd2, 32'h10);
        tmr_write(2'd3, 32'h0);
        wait_req(40);
        chk("timer_cause", 64'(bus.o_trap_cause), 64'h8000_0007);
        chk("timer_mtime", 64'(bus.o_tmr_rdata), 64'h12);
        ack_cycle();
        chk("timer_in_trap", 64'(bus.o_in_trap), 64'd1);
        en.enable_timer = 1'b0;
        mret_cycle();
        tmr_write(2'd2, 32'hFFFF_FFFF);
        tmr_write(2'd3, 32'hFFFF_FFFF);

        // Simultaneous external and soft: external wins first
        mie = 1'b0; en = '{enable_external: 1'b1, enable_timer: 1'b0, enable_soft: 1'b1};
        irq_ext = 1'b1; irq_soft = 1'b1;
        tick(4);
        mie = 1'b1;
        wait_req(10);
        chk("prio_first", 64'(bus.o_trap_cause), 64'h8000_000B);
        ack_cycle();
        irq_ext = 1'b0;
        tick(3);
        mret_cycle();
        wait_req(10);
        chk("prio_second", 64'(bus.o_trap_cause), 64'h8000_0003);
        ack_cycle();
        irq_soft = 1'b0;
        tick(2);
        mret_cycle();

        // Request is not withdrawn when the enable drops
        irq_ext = 1'b1;
        wait_req(10);
        en.enable_external = 1'b0; irq_ext = 1'b0;
        tick(5);
        chk("hold_req", 64'(bus.o_trap_req), 64'd1);
        chk("hold_cause", 64'(bus.o_trap_cause), 64'h8000_000B);
        ack_cycle();
        mret_cycle();

        // mtime wrap through all-ones
        tmr_write(2'd0, 32'hFFFF_FFFF);
        tmr_write(2'd1, 32'hFFFF_FFFF);
        tick();
        chk("wrap_lo", 64'(bus.o_tmr_rdata), 64'd0);
        bus.i_tmr_sel = 2'd1; #1;
        chk("wrap_hi", 64'(bus.o_tmr_rdata), 64'd0);

        // Global disable masks everything while pending stays visible
        mie = 1'b0; en = '1; irq_ext = 1'b1; irq_soft = 1'b1;
        tmr_write(2'd3, 32'h0);
        tmr_write(2'd2, 32'h0);
        tick(6);
        chk("mie_off_req", 64'(bus.o_trap_req), 64'd0);
        chk("mie_off_pend", 64'(st), 64'b111);

        // Reset while in the handler
        mie = 1'b1;
        wait_req(10);
        ack_cycle();
        chk("active_in_trap", 64'(bus.o_in_trap), 64'd1);
        rst_n = 1'b0; bus.i_tmr_sel = 2'd2;
        tick();
        rst_n = 1'b1;
        chk("rst_in_trap", 64'(bus.o_in_trap), 64'd0);
        chk("rst_req", 64'(bus.o_trap_req), 64'd0);
        chk("rst_cmp_lo", 64'(bus.o_tmr_rdata), 64'hFFFF_FFFF);
        bus.i_tmr_sel = 2'd3; #1;
        chk("rst_cmp_hi2", 64'(bus.o_tmr_rdata), 64'hFFFF_FFFF);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom % 250) != 0;
            if ($urandom % 8 == 0) irq_ext = ~irq_ext;
            if ($urandom % 8 == 0) irq_soft = ~irq_soft;
            if ($urandom % 16 == 0) en = 3'($urandom);
            mie = ($urandom % 8) != 0;
            bus.i_trap_ack = ($urandom % 4) == 0;
            bus.i_mret = ($urandom % 4) == 0;
            bus.i_tmr_we = ($urandom % 16) == 0;
            bus.i_tmr_sel = 2'($urandom);
            bus.i_tmr_wdata = ($urandom % 4 == 0) ? $urandom : ($urandom % 64);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
